// File: rtl/sync_debounce_pkg.sv
// Shared types and elaboration helpers for the debounced-input conditioner.
package sync_debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } deb_state_e;

   // Width able to hold DEBOUNCE_CYCLES-1, never narrower than one bit.
   function automatic int deb_cnt_w(input int cycles);
      return (cycles <= 2) ? 1 : $clog2(cycles);
   endfunction

   function automatic bit deb_params_ok(input int sync_stages,
                                        input int debounce_cycles,
                                        input int glitch_w);
      return (sync_stages >= 2) && (sync_stages <= 4) &&
             (debounce_cycles >= 2) && (glitch_w >= 1);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; reusable for any async input.
module sync_chain #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronises and debounces one bouncy input; emits level, edge pulses and a glitch count.
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter int   GLITCH_W        = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                raw_i,
   input  logic                glitch_clr_i,
   output logic                level_o,
   output logic                rise_o,
   output logic                fall_o,
   output logic                busy_o,
   output logic [GLITCH_W-1:0] glitch_cnt_o
);

   localparam int               CNT_W       = deb_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam deb_state_e       RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   if (!deb_params_ok(SYNC_STAGES, DEBOUNCE_CYCLES, GLITCH_W)) begin : g_param_check
      $error("sync_debounce: illegal SYNC_STAGES/DEBOUNCE_CYCLES/GLITCH_W");
   end

   function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
      return (v == {GLITCH_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic       s_sync;
   deb_state_e state_q;
   logic [CNT_W-1:0] cnt_q;
   logic       glitch;

   sync_chain #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (RESET_LEVEL)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (raw_i),
      .q_o    (s_sync)
   );

   // A reversal while qualifying is a rejected transition.
   assign glitch = ((state_q == WAIT_HI) && !s_sync) || ((state_q == WAIT_LO) && s_sync);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
         level_o <= RESET_LEVEL;
         rise_o  <= 1'b0;
         fall_o  <= 1'b0;
         busy_o  <= 1'b0;
      end else begin
         rise_o <= 1'b0;
         fall_o <= 1'b0;
         case (state_q)
            STABLE_LO: begin
               if (s_sync) begin
                  state_q <= WAIT_HI;
                  cnt_q   <= CNT_ONE;
                  busy_o  <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  busy_o <= 1'b0;
               end
            end
            WAIT_HI: begin
               if (!s_sync) begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
                  busy_o  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= STABLE_HI;
                  cnt_q   <= '0;
                  level_o <= 1'b1;
                  rise_o  <= 1'b1;
                  busy_o  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!s_sync) begin
                  state_q <= WAIT_LO;
                  cnt_q   <= CNT_ONE;
                  busy_o  <= 1'b1;
               end else begin
                  cnt_q  <= '0;
                  busy_o <= 1'b0;
               end
            end
            WAIT_LO: begin
               if (s_sync) begin
                  state_q <= STABLE_HI;
                  cnt_q   <= '0;
                  busy_o  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= STABLE_LO;
                  cnt_q   <= '0;
                  level_o <= 1'b0;
                  fall_o  <= 1'b1;
                  busy_o  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
         endcase
      end
   end

   // Clear wins over a same-cycle glitch so software sees a clean zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         glitch_cnt_o <= '0;
      end else if (glitch_clr_i) begin
         glitch_cnt_o <= '0;
      end else if (glitch) begin
         glitch_cnt_o <= sat_inc(glitch_cnt_o);
      end
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Randomised scoreboard bench for sync_debounce with a window-based reference model.
module tb_sync_debounce;

   localparam int   SYNC_STAGES     = 2;
   localparam int   DEBOUNCE_CYCLES = 4;
   localparam logic RESET_LEVEL     = 1'b0;
   localparam int   GLITCH_W        = 8;
   localparam int   GMAX            = (1 << GLITCH_W) - 1;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic raw_i = 1'b0;
   logic glitch_clr_i = 1'b0;
   logic level_o, rise_o, fall_o, busy_o;
   logic [GLITCH_W-1:0] glitch_cnt_o;

   sync_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL),
      .GLITCH_W        (GLITCH_W)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .raw_i        (raw_i),
      .glitch_clr_i (glitch_clr_i),
      .level_o      (level_o),
      .rise_o       (rise_o),
      .fall_o       (fall_o),
      .busy_o       (busy_o),
      .glitch_cnt_o (glitch_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic                level;
      logic                rise;
      logic                fall;
      logic                busy;
      logic [GLITCH_W-1:0] gcnt;
   } obs_t;

   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: raw history, delayed sample history, current level, glitch count.
   logic m_level;
   int   m_gcnt;
   logic raw_h[$];
   logic smp_h[$];

   task automatic model_reset();
      m_level = RESET_LEVEL;
      m_gcnt  = 0;
      raw_h.delete();
      smp_h.delete();
   endtask

   // Level flips once the last DEBOUNCE_CYCLES delayed samples all disagree with it;
   // a sample agreeing with the level right after a disagreeing one is a rejected glitch.
   task automatic model_edge(input logic r, input logic c, output obs_t e);
      logic x, prev_level, prev_smp, flip, glitch;
      int   n;
      raw_h.push_back(r);
      x = (raw_h.size() > SYNC_STAGES) ? raw_h[raw_h.size()-1-SYNC_STAGES] : RESET_LEVEL;
      prev_level = m_level;
      prev_smp   = (smp_h.size() > 0) ? smp_h[smp_h.size()-1] : RESET_LEVEL;
      smp_h.push_back(x);
      n = smp_h.size();
      flip = (n >= DEBOUNCE_CYCLES);
      for (int i = 0; i < DEBOUNCE_CYCLES && flip; i++)
         if (smp_h[n-1-i] == prev_level) flip = 1'b0;
      glitch = (prev_smp != prev_level) && (x == prev_level);
      if (flip) m_level = ~prev_level;
      if (c) m_gcnt = 0;
      else if (glitch && m_gcnt < GMAX) m_gcnt++;
      e.level = m_level;
      e.rise  = flip && m_level;
      e.fall  = flip && !m_level;
      e.busy  = (x != m_level);
      e.gcnt  = m_gcnt[GLITCH_W-1:0];
   endtask

   function automatic obs_t dut_obs();
      obs_t o;
      o.level = level_o;
      o.rise  = rise_o;
      o.fall  = fall_o;
      o.busy  = busy_o;
      o.gcnt  = glitch_cnt_o;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Drive one cycle at the falling edge and queue the response expected after the next rising edge.
   task automatic step(input logic r, input logic c);
      obs_t e;
      @(negedge clk);
      raw_i        = r;
      glitch_clr_i = c;
      model_edge(r, c, e);
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic r, input int n);
      repeat (n) step(r, 1'b0);
   endtask

   // Called at a falling edge: leave reset and queue the response for the very next rising edge.
   task automatic release_rst(input logic r);
      obs_t e;
      rst_ni       = 1'b1;
      raw_i        = r;
      glitch_clr_i = 1'b0;
      model_edge(r, 1'b0, e);
      exp_q.push_back(e);
   endtask

   // Monitor: compares every presented output cycle against the queued expectation.
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_obs();
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle_out t=%0t: actual lvl=%b rise=%b fall=%b busy=%b gcnt=%0d required lvl=%b rise=%b fall=%b busy=%b gcnt=%0d",
                        $time, a.level, a.rise, a.fall, a.busy, a.gcnt,
                        e.level, e.rise, e.fall, e.busy, e.gcnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic v;
      int   len;
      logic pat [6];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

      model_reset();
      rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_level", level_o, 0);
      check("rst_rise", rise_o, 0);
      check("rst_fall", fall_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_gcnt", glitch_cnt_o, 0);
      release_rst(1'b0);

      // Clean rise, then clean fall.
      hold(1'b0, 8);
      hold(1'b1, 8);
      check("t1_level_hi", level_o, 1);
      hold(1'b0, 8);
      check("t4_level_lo", level_o, 0);

      // Short high pulse is rejected.
      hold(1'b1, 2);
      hold(1'b0, 6);
      check("t2_gcnt", glitch_cnt_o, 1);
      check("t2_level", level_o, 0);

      // Bounce then settle high.
      foreach (pat[i]) step(pat[i], 1'b0);
      hold(1'b1, 8);
      check("t3_gcnt", glitch_cnt_o, 3);
      check("t3_level", level_o, 1);

      // Random runs with occasional clears.
      repeat (40) begin
         v   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 7);
         repeat (len) step(v, ($urandom_range(0, 15) == 0));
      end

      // Saturation and clear-priority.
      step(1'b0, 1'b1);
      hold(1'b0, 7);
      repeat (260) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b0);
      end
      hold(1'b0, 4);
      check("t5_gcnt_sat", glitch_cnt_o, GMAX);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      hold(1'b0, 2);
      check("t5_gcnt_clr", glitch_cnt_o, 0);

      // Reset while qualifying a rise at cnt=2.
      hold(1'b1, 4);
      @(negedge clk);
      check("t6_busy_pre", busy_o, 1);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_busy", busy_o, 0);
      check("t6_rst_level", level_o, 0);
      check("t6_rst_rise", rise_o, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check("t6_hold_level", level_o, 0);
      release_rst(1'b1);
      hold(1'b1, 8);
      check("t6_level_after", level_o, 1);

      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Conditions one asynchronous, bouncy external input (button, switch, slow sensor line) for the clk_i domain.
- Sits directly upstream of the single-cycle edge-capture stages, which assume a clean, synchronous, slower-than-clock pulse.
- Synchronises the raw input, rejects bounces shorter than DEBOUNCE_CYCLES, and drives a stable level_o.
- Also produces aligned one-cycle rise/fall pulses and a saturating count of rejected glitches for diagnostics.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on raw_i; legal range 2..4.
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronised input must hold a new value before level_o follows; minimum 2.
- RESET_LEVEL, 1'b0, value of the synchroniser flops, the FSM stable state and level_o in reset.
- GLITCH_W, 8, width of the glitch counter.

Ports:
- clk_i  input  1  system clock; all state on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset; reset is asserted asynchronously, and deassertion is handled by the system reset synchroniser.
- raw_i  input  1  asynchronous raw input.
- glitch_clr_i  input  1  synchronous clear of glitch_cnt_o.
- level_o  output  1  debounced level.
- rise_o  output  1  one-cycle pulse in the cycle level_o goes 0->1.
- fall_o  output  1  one-cycle pulse in the cycle level_o goes 1->0.
- busy_o  output  1  high while the FSM is in a WAIT state.
- glitch_cnt_o  output  GLITCH_W  saturating count of rejected transitions.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - Synchroniser flops = RESET_LEVEL; state = STABLE_LO if RESET_LEVEL=0, else STABLE_HI.
  - cnt=0, level_o=RESET_LEVEL, rise_o=fall_o=busy_o=0, glitch_cnt_o=0.
  - Reset mid-WAIT abandons the pending transition; no pulse is emitted.
- Synchroniser: s = last stage of the SYNC_STAGES chain. Edge k samples raw_i into stage 1; s reflects it after edge k+SYNC_STAGES-1.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. cnt width = $clog2(DEBOUNCE_CYCLES).
  - STABLE_LO: s=1 -> WAIT_HI, cnt<=1. Otherwise stay, cnt<=0.
  - WAIT_HI:
    - s=0 -> STABLE_LO, cnt<=0, glitch_cnt_o increments.
    - else if cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level_o<=1, rise_o<=1 for one cycle.
    - else cnt<=cnt+1.
  - STABLE_HI and WAIT_LO mirror the above with polarity inverted; fall_o pulses on the transition to STABLE_LO.
- busy_o is high exactly when state is WAIT_HI or WAIT_LO (registered state decode).
- Latency: raw_i stable from edge k onwards gives level_o updated after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. rise_o/fall_o are asserted in the same cycle that level_o changes.
- Any reversal of s during WAIT restarts the qualification from the stable state. A held input therefore needs a full, uninterrupted DEBOUNCE_CYCLES window.
- rise_o and fall_o are never both high; each is high for exactly one cycle per level_o change.
- glitch_cnt_o:
  - Saturates at 2^GLITCH_W-1.
  - glitch_clr_i has priority over a simultaneous increment, giving 0 that cycle.
  - The clear does not affect the FSM.
- No combinational path from any input to any output.

Decomposition:
- Package sync_debounce_pkg:
  - State enum type deb_state_e with 2-bit encoding.
  - Constant function deriving the counter width.
  - Parameter legality checks, implemented as elaboration-time assertions.
- Sub-module sync_chain (params STAGES, RESET_VAL; ports clk_i, rst_ni, d_i, q_o). It is reusable for other asynchronous inputs in the codebase.
- The FSM, counter and glitch counter stay in sync_debounce.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0, GLITCH_W=8.
1. Reset, then raw_i=1 before edge 10 and held -> level_o=1 and rise_o=1 after edge 15 only; rise_o=0 after edge 16; busy_o high after edges 12..14.
2. raw_i high for 2 cycles then low -> level_o stays 0, no rise_o, glitch_cnt_o=1.
3. Bounce pattern 1,0,1,1,0,1 then steady 1 -> exactly one rise_o, 4+2-1 cycles after the final steady edge; glitch_cnt_o equals the number of rejected reversals, which the model computes.
4. Steady 1, then raw_i=0 held -> fall_o single pulse with level_o 1->0 at +5 edges; rise_o stays 0 throughout.
5. Drive 260 short glitches -> glitch_cnt_o saturates at 255. Assert glitch_clr_i coincident with a glitch -> count=0.
6. rst_ni pulsed low in WAIT_HI at cnt=2 -> all outputs return immediately to reset values with no pulse. After release with raw_i still 1, the full 5-edge qualification restarts.
